// File: rtl/fc_pkg.sv
// Shared fast-control definitions: word layout constants, command codes and
// decoder state encoding, used by both the encoder and the receive-side decoder.
package fc_pkg;

    localparam logic [3:0]  FC_HDR_IDLE  = 4'h5;
    localparam logic [3:0]  FC_HDR_CMD   = 4'hA;
    localparam logic [15:0] FC_IDLE_WORD = 16'h5000;

    typedef enum logic [2:0] {
        FC_CMD_NONE       = 3'd0,
        FC_CMD_L1A        = 3'd1,
        FC_CMD_BCR        = 3'd2,
        FC_CMD_OCR        = 3'd3,
        FC_CMD_CALIB      = 3'd4,
        FC_CMD_LINK_RESET = 3'd5,
        FC_CMD_RSVD6      = 3'd6,
        FC_CMD_RSVD7      = 3'd7
    } fc_cmd_e;

    typedef enum logic [1:0] {
        FC_UNLOCKED = 2'd0,
        FC_ACQUIRE  = 2'd1,
        FC_LOCKED   = 2'd2
    } fc_state_e;

    typedef struct packed {
        logic l1a;
        logic bcr;
        logic ocr;
        logic calib;
        logic link_reset;
    } fc_strobe_t;

    // Builds a command word with the parity bit chosen so the whole word has even parity.
    function automatic logic [15:0] fc_make_word(input fc_cmd_e cmd, input logic [7:0] aux);
        logic parity;
        parity = ^{FC_HDR_CMD, cmd, aux};
        return {FC_HDR_CMD, parity, cmd, aux};
    endfunction

    function automatic logic [15:0] fc_sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fc_word_check.sv
// Combinational legality check of one encoded fast-control word: header,
// even parity over all 16 bits, and command code range.
module fc_word_check
    import fc_pkg::*;
(
    input  logic [15:0] word,
    output logic        valid,
    output logic        is_cmd,
    output fc_cmd_e     cmd,
    output logic [7:0]  aux
);

    logic [3:0] header;
    logic       parity_ok;
    logic       cmd_legal;

    assign header    = word[15:12];
    assign parity_ok = ~(^word);
    assign cmd       = fc_cmd_e'(word[10:8]);
    assign aux       = word[7:0];

    // NOTE: default first so every path assigns cmd_legal; otherwise a latch is inferred.
    always_comb begin
        cmd_legal = 1'b0;
        case (cmd)
            FC_CMD_L1A, FC_CMD_BCR, FC_CMD_OCR,
            FC_CMD_CALIB, FC_CMD_LINK_RESET: cmd_legal = 1'b1;
            default:                         cmd_legal = 1'b0;
        endcase
    end

    assign is_cmd = (header == FC_HDR_CMD) && parity_ok && cmd_legal;
    // The idle word is fully specified, so a single compare covers header, parity and payload.
    assign valid  = is_cmd || (word == FC_IDLE_WORD);

endmodule

// File: rtl/fc_stream_decoder.sv
// Receive-side fast-control decoder: word-lock FSM, single-cycle command strobes,
// local BX/orbit tracking and saturating error/monitor counters.
module fc_stream_decoder
    import fc_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int BX_PER_ORBIT = 3564
) (
    input  logic        clk_bx,
    input  logic        reset,
    input  logic [15:0] fc_stream_enc,
    input  logic        clear_counters,
    output logic        locked,
    output logic        l1a,
    output logic        bcr,
    output logic        ocr,
    output logic        calib,
    output logic        link_reset,
    output logic [7:0]  cmd_aux,
    output logic [11:0] bx_count,
    output logic [15:0] orbit_count,
    output logic [15:0] err_count,
    output logic [15:0] bcr_mismatch_count,
    output logic [31:0] l1a_count
);

    localparam int          GW     = $clog2(LOCK_COUNT + 1);
    localparam int          BW     = $clog2(UNLOCK_COUNT + 1);
    localparam logic [11:0] BX_MAX = 12'(BX_PER_ORBIT - 1);

    logic [15:0] word_q;
    logic        w_valid;
    logic        w_is_cmd;
    fc_cmd_e     w_cmd;
    logic [7:0]  w_aux;

    fc_state_e   state, state_d;
    logic [GW-1:0] good_cnt, good_d;
    logic [BW-1:0] bad_cnt, bad_d;
    logic        decode_en;
    logic        err_inc;
    logic        cmd_fire;
    fc_strobe_t  strobe_d, strobe_q;

    // Stage 1: input register.
    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    // NOTE: every register, including pipeline stages, is cleared by the async reset so outputs drop at once.
    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) word_q <= '0;
        else       word_q <= fc_stream_enc;
    end

    fc_word_check u_word_check (
        .word   (word_q),
        .valid  (w_valid),
        .is_cmd (w_is_cmd),
        .cmd    (w_cmd),
        .aux    (w_aux)
    );

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            state    <= FC_UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_d;
            good_cnt <= good_d;
            bad_cnt  <= bad_d;
        end
    end

    // decode_en is also raised on the word that completes lock, so that word is decoded.
    always_comb begin
        state_d   = state;
        good_d    = good_cnt;
        bad_d     = bad_cnt;
        decode_en = 1'b0;
        err_inc   = 1'b0;
        case (state)
            FC_UNLOCKED, FC_ACQUIRE: begin
                if (w_valid) begin
                    good_d = (state == FC_UNLOCKED) ? GW'(1) : good_cnt + GW'(1);
                    if (good_d == GW'(LOCK_COUNT)) begin
                        state_d   = FC_LOCKED;
                        good_d    = '0;
                        bad_d     = '0;
                        decode_en = 1'b1;
                    end else begin
                        state_d = FC_ACQUIRE;
                    end
                end else begin
                    state_d = FC_UNLOCKED;
                    good_d  = '0;
                end
            end
            FC_LOCKED: begin
                if (w_valid) begin
                    bad_d     = '0;
                    decode_en = 1'b1;
                end else begin
                    err_inc = 1'b1;
                    bad_d   = bad_cnt + BW'(1);
                    if (bad_d == BW'(UNLOCK_COUNT)) begin
                        state_d = FC_UNLOCKED;
                        bad_d   = '0;
                    end
                end
            end
            default: begin
                state_d = FC_UNLOCKED;
                good_d  = '0;
                bad_d   = '0;
            end
        endcase
    end

    assign cmd_fire = decode_en && w_is_cmd;

    always_comb begin
        strobe_d            = '0;
        strobe_d.l1a        = cmd_fire && (w_cmd == FC_CMD_L1A);
        strobe_d.bcr        = cmd_fire && (w_cmd == FC_CMD_BCR);
        strobe_d.ocr        = cmd_fire && (w_cmd == FC_CMD_OCR);
        strobe_d.calib      = cmd_fire && (w_cmd == FC_CMD_CALIB);
        strobe_d.link_reset = cmd_fire && (w_cmd == FC_CMD_LINK_RESET);
    end

    // Stage 2: strobes and the command payload.
    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            strobe_q <= '0;
            cmd_aux  <= '0;
        end else begin
            strobe_q <= strobe_d;
            if (cmd_fire) cmd_aux <= w_aux;
        end
    end

    // bx_count still holds the previous cycle's value when a BCR is decoded.
    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            bx_count    <= '0;
            orbit_count <= '0;
        end else begin
            if (strobe_d.bcr)             bx_count <= '0;
            else if (state == FC_LOCKED)  bx_count <= (bx_count == BX_MAX) ? 12'd0 : bx_count + 12'd1;

            if (strobe_d.ocr)             orbit_count <= '0;
            else if (strobe_d.bcr)        orbit_count <= orbit_count + 16'd1;
        end
    end

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            err_count          <= '0;
            bcr_mismatch_count <= '0;
            l1a_count          <= '0;
        end else if (clear_counters) begin
            err_count          <= '0;
            bcr_mismatch_count <= '0;
            l1a_count          <= '0;
        end else begin
            if (err_inc)                             err_count <= fc_sat_inc16(err_count);
            if (strobe_d.bcr && bx_count != BX_MAX)  bcr_mismatch_count <= fc_sat_inc16(bcr_mismatch_count);
            if (strobe_d.l1a)                        l1a_count <= l1a_count + 32'd1;
        end
    end

    assign locked     = (state == FC_LOCKED);
    assign l1a        = strobe_q.l1a;
    assign bcr        = strobe_q.bcr;
    assign ocr        = strobe_q.ocr;
    assign calib      = strobe_q.calib;
    assign link_reset = strobe_q.link_reset;

endmodule

// File: tb/tb_fc_stream_decoder.sv
// Directed self-checking bench for fc_stream_decoder with hand-computed command
// words (even parity) and expected counter values.
module tb_fc_stream_decoder;

    localparam logic [15:0] IDLE     = 16'h5000;
    localparam logic [15:0] BAD      = 16'h0000;
    localparam logic [15:0] W_L1A_3C = 16'hA93C;
    localparam logic [15:0] W_BCR    = 16'hAA00;
    localparam logic [15:0] W_L1A_BP = 16'hA13C;
    localparam logic [15:0] W_CMD6   = 16'hA600;

    logic        clk_bx;
    logic        reset;
    logic [15:0] fc_stream_enc;
    logic        clear_counters;
    logic        locked, l1a, bcr, ocr, calib, link_reset;
    logic [7:0]  cmd_aux;
    logic [11:0] bx_count;
    logic [15:0] orbit_count, err_count, bcr_mismatch_count;
    logic [31:0] l1a_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] cmd_word  [4] = '{16'hAA00, 16'hA300, 16'hAC55, 16'hA581};
    logic [4:0]  cmd_vec   [4] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001};
    logic [7:0]  cmd_auxv  [4] = '{8'h00, 8'h00, 8'h55, 8'h81};
    logic [15:0] cmd_orbit [4] = '{16'd1, 16'd0, 16'd0, 16'd0};

    fc_stream_decoder dut (
        .clk_bx             (clk_bx),
        .reset              (reset),
        .fc_stream_enc      (fc_stream_enc),
        .clear_counters     (clear_counters),
        .locked             (locked),
        .l1a                (l1a),
        .bcr                (bcr),
        .ocr                (ocr),
        .calib              (calib),
        .link_reset         (link_reset),
        .cmd_aux            (cmd_aux),
        .bx_count           (bx_count),
        .orbit_count        (orbit_count),
        .err_count          (err_count),
        .bcr_mismatch_count (bcr_mismatch_count),
        .l1a_count          (l1a_count)
    );

    initial clk_bx = 1'b0;
    always #5 clk_bx = ~clk_bx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a word, let it be sampled on the next rising edge, then settle 1 ns.
    task automatic step(input logic [15:0] w);
        fc_stream_enc = w;
        @(posedge clk_bx);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {l1a, bcr, ocr, calib, link_reset};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_strobes"}, 32'(strobes()), 32'd0);
        check({tag, "_aux"}, 32'(cmd_aux), 32'd0);
        check({tag, "_bx"}, 32'(bx_count), 32'd0);
        check({tag, "_orbit"}, 32'(orbit_count), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_mism"}, 32'(bcr_mismatch_count), 32'd0);
        check({tag, "_l1acnt"}, l1a_count, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        fc_stream_enc  = BAD;
        clear_counters = 1'b0;
        repeat (3) @(posedge clk_bx);
        #1;
        check_all_zero("reset");
        #2 reset = 1'b0;

        // Lock acquisition: 16 idles decode one edge after the 16th is sampled.
        repeat (16) step(IDLE);
        check("lock_before_16th_decoded", 32'(locked), 32'd0);
        step(IDLE);
        check("lock_after_16th", 32'(locked), 32'd1);

        // Lock loss: two invalid keep lock, four drop it.
        step(BAD); step(BAD); step(BAD);
        check("err_after_2_bad", 32'(err_count), 32'd2);
        check("locked_after_2_bad", 32'(locked), 32'd1);
        step(BAD); step(IDLE);
        check("err_after_4_bad", 32'(err_count), 32'd4);
        check("unlocked_after_4_bad", 32'(locked), 32'd0);

        repeat (17) step(IDLE);
        check("relock", 32'(locked), 32'd1);

        // L1A strobe latency and single-cycle width.
        step(W_L1A_3C);
        check("l1a_not_early", 32'(strobes()), 32'd0);
        step(IDLE);
        check("l1a_strobe", 32'(strobes()), 32'b10000);
        check("l1a_aux", 32'(cmd_aux), 32'h3C);
        check("l1a_count_1", l1a_count, 32'd1);
        step(IDLE);
        check("l1a_one_cycle", 32'(strobes()), 32'd0);

        for (int i = 0; i < 4; i++) begin
            step(cmd_word[i]);
            step(IDLE);
            check($sformatf("cmd%0d_strobe", i + 2), 32'(strobes()), 32'(cmd_vec[i]));
            check($sformatf("cmd%0d_aux", i + 2), 32'(cmd_aux), 32'(cmd_auxv[i]));
            check($sformatf("cmd%0d_orbit", i + 2), 32'(orbit_count), 32'(cmd_orbit[i]));
            step(IDLE);
            check($sformatf("cmd%0d_drop", i + 2), 32'(strobes()), 32'd0);
        end
        check("l1a_count_after_cmds", l1a_count, 32'd1);

        // Bad parity and illegal command code: counted as errors, no strobes.
        step(W_L1A_BP);
        step(W_CMD6);
        check("badpar_no_strobe", 32'(strobes()), 32'd0);
        step(IDLE);
        check("cmd6_no_strobe", 32'(strobes()), 32'd0);
        check("err_after_illegal", 32'(err_count), 32'd6);
        check("l1a_count_unchanged", l1a_count, 32'd1);
        check("aux_held", 32'(cmd_aux), 32'h81);
        check("locked_after_illegal", 32'(locked), 32'd1);

        // Clear on the same edge as an error increment.
        step(BAD);
        clear_counters = 1'b1;
        step(IDLE);
        clear_counters = 1'b0;
        check("clear_wins_err", 32'(err_count), 32'd0);
        check("clear_l1a_count", l1a_count, 32'd0);
        check("clear_mism", 32'(bcr_mismatch_count), 32'd0);

        // BX/BCR alignment: second BCR exactly one orbit after the first.
        step(W_BCR);
        step(IDLE);
        check("bcr1_strobe", 32'(bcr), 32'd1);
        check("bcr1_bx", 32'(bx_count), 32'd0);
        check("bcr1_orbit", 32'(orbit_count), 32'd1);
        clear_counters = 1'b1;
        step(IDLE);
        clear_counters = 1'b0;
        repeat (3561) step(IDLE);
        step(W_BCR);
        check("bx_at_orbit_end", 32'(bx_count), 32'd3563);
        step(IDLE);
        check("bcr2_strobe", 32'(bcr), 32'd1);
        check("bcr2_bx", 32'(bx_count), 32'd0);
        check("bcr2_orbit", 32'(orbit_count), 32'd2);
        check("bcr2_no_mism", 32'(bcr_mismatch_count), 32'd0);
        repeat (98) step(IDLE);
        step(W_BCR);
        step(IDLE);
        check("bcr3_bx", 32'(bx_count), 32'd0);
        check("bcr3_orbit", 32'(orbit_count), 32'd3);
        check("bcr3_mism", 32'(bcr_mismatch_count), 32'd1);

        // Error saturation: groups of three invalid words never drop lock.
        clear_counters = 1'b1;
        step(IDLE);
        clear_counters = 1'b0;
        for (int g = 0; g < 100; g++) begin
            step(BAD); step(BAD); step(BAD); step(IDLE);
        end
        check("err_mid_count", 32'(err_count), 32'd300);
        for (int g = 0; g < 21746; g++) begin
            step(BAD); step(BAD); step(BAD); step(IDLE);
        end
        check("err_saturated", 32'(err_count), 32'hFFFF);
        check("locked_after_sat", 32'(locked), 32'd1);

        // Asynchronous reset while an L1A strobe is high.
        step(W_L1A_3C);
        step(IDLE);
        check("l1a_before_reset", 32'(l1a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        reset = 1'b0;
        repeat (16) step(IDLE);
        check("relock_not_yet", 32'(locked), 32'd0);
        step(IDLE);
        check("relock_after_reset", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
